// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle ops (add/and/or/nor/slt/sll/srl/sub) register their result one
// clock after capture. MUL is an iterative shift-add unit producing a
// double-width product. DIV/REM use an iterative restoring divider that is
// only built when the macro ALU_MC_DIV_EN is defined. Without the macro,
// opcodes 1001/1010 decode as add and dbz is tied low.
//
// Handshake: start is sampled only in IDLE. busy is high while an iterative
// op runs. done pulses for one cycle whenever result/flags update.
// The FSM state is visible on state_dbg (0=IDLE, 1=ITER, 2=FIN).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       select,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             v,
    output logic             dbz,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_REM = 4'b1010;
`endif

    localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SHW-1:0]   sh_q;
    logic [3:0]       op_q;
    logic             pend;     // a single-cycle op was captured last edge
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_hi;   // mul: product high half / div: partial remainder
    logic [WIDTH-1:0] acc_lo;   // mul: multiplier, shifting out / div: dividend -> quotient

    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] dif_ab;
    logic [WIDTH-1:0] sc_res;
    logic             sc_v;
    logic             is_iter_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic             dbz_q;
`endif

    assign state_dbg = 2'(state);

`ifdef ALU_MC_DIV_EN
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    // Decode which opcodes take the iterative path.
    always_comb begin
        is_iter_op = (select == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if ((select == OP_DIV) || (select == OP_REM)) begin
            is_iter_op = 1'b1;
        end
`endif
    end

    // Single-cycle result and overflow, computed from the captured operands.
    always_comb begin
        sum_ab = a_q + b_q;
        dif_ab = a_q - b_q;
        sc_res = sum_ab;
        sc_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ab[WIDTH-1] != a_q[WIDTH-1]);
        case (op_q)
            OP_ADD: begin end
            OP_AND: begin sc_res = a_q & b_q;    sc_v = 1'b0; end
            OP_OR:  begin sc_res = a_q | b_q;    sc_v = 1'b0; end
            OP_NOR: begin sc_res = ~(a_q | b_q); sc_v = 1'b0; end
            OP_SLT: begin
                sc_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
                sc_v   = 1'b0;
            end
            OP_SLL: begin sc_res = a_q << sh_q;  sc_v = 1'b0; end
            OP_SRL: begin sc_res = a_q >> sh_q;  sc_v = 1'b0; end
            OP_SUB: begin
                sc_res = dif_ab;
                // Subtracting B overflows when A and B differ in sign and the
                // result sign departs from A.
                sc_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_ab[WIDTH-1] != a_q[WIDTH-1]);
            end
            default: begin end
        endcase
    end

    // One iteration of shift-add multiply and (optionally) restoring divide.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        {mul_hi_n, mul_lo_n} = {mul_sum, acc_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // With b_q == 0 every step succeeds, so the quotient becomes all ones
        // and the remainder ends up equal to the dividend.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = ~div_diff[WIDTH];
`endif
    end

    // Control FSM plus registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            z         <= 1'b1;
            v         <= 1'b0;
            pend      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            op_q      <= '0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
`ifdef ALU_MC_DIV_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            pend <= 1'b0;

            if (pend) begin
                result    <= sc_res;
                result_hi <= '0;
                z         <= (sc_res == '0);
                v         <= sc_v;
                done      <= 1'b1;
`ifdef ALU_MC_DIV_EN
                dbz_q     <= 1'b0;
`endif
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        sh_q <= shamt;
                        op_q <= select;
                        if (is_iter_op) begin
                            state  <= S_ITER;
                            cnt    <= CNT_LOAD;
                            acc_hi <= '0;
                            acc_lo <= a_in;
                        end else begin
                            pend <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    busy <= 1'b1;
`ifdef ALU_MC_DIV_EN
                    if (op_q == OP_MUL) begin
                        acc_hi <= mul_hi_n;
                        acc_lo <= mul_lo_n;
                    end else begin
                        acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end
`else
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
`endif
                    if (cnt == '0) begin
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    v     <= 1'b0;
                    state <= S_IDLE;
`ifdef ALU_MC_DIV_EN
                    if (op_q == OP_DIV) begin
                        result    <= acc_lo;
                        result_hi <= '0;
                        z         <= (acc_lo == '0);
                    end else if (op_q == OP_REM) begin
                        result    <= acc_hi;
                        result_hi <= '0;
                        z         <= (acc_hi == '0);
                    end else begin
                        result    <= acc_lo;
                        result_hi <= acc_hi;
                        z         <= (acc_lo == '0);
                    end
                    dbz_q <= (op_q != OP_MUL) && (b_q == '0);
`else
                    result    <= acc_lo;
                    result_hi <= acc_hi;
                    z         <= (acc_lo == '0);
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc at WIDTH=8 with directed vectors.
// Expected responses are pushed into exp_q when an op is issued; the monitor
// pops and compares every time done is seen. DIV/REM vectors are selected by
// ALU_MC_DIV_EN.
module tb_alu_mc;

    localparam int W  = 8;
    localparam int SW = 3;
    localparam int EW = 2 * W + 3;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    select = 4'b0000;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [SW-1:0] shamt = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          z;
    logic          v;
    logic          dbz;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .SHW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .select    (select),
        .a_in      (a_in),
        .b_in      (b_in),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .z         (z),
        .v         (v),
        .dbz       (dbz),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int           total  = 0;
    int           passed = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic logic [EW-1:0] pack(input logic [W-1:0] res, input logic [W-1:0] hi,
                                           input logic ez, input logic ev, input logic ed);
        return {ed, ev, ez, hi, res};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: done with no pending op, result=0x%0h", result);
            end else begin
                exp_e = exp_q.pop_front();
                chk("result",    result,    exp_e[W-1:0]);
                chk("result_hi", result_hi, exp_e[2*W-1:W]);
                chk("z",         z,         exp_e[2*W]);
                chk("v",         v,         exp_e[2*W+1]);
                chk("dbz",       dbz,       exp_e[2*W+2]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one op (called right after a negedge), scramble inputs afterwards,
    // then check done latency, busy cycle count and the single-cycle done pulse.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh, input logic [EW-1:0] exp_v,
                          input int exp_lat, input bit mid_pulse, input string tag);
        int lat    = 0;
        int busy_n = 0;
        bit got    = 0;
        select = op; a_in = a; b_in = b; shamt = sh; start = 1'b1;
        exp_q.push_back(exp_v);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            start = (mid_pulse && i == 4);
            if (i == 1) begin
                a_in = ~a; b_in = ~b; select = 4'b0000;
            end
            if (busy) busy_n++;
            if (done) begin
                got = 1;
                lat = i;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_n, exp_lat - 2);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run_b2b();
        int n = 0;
        select = 4'b0111; a_in = 8'h05; b_in = 8'h05; start = 1'b1;
        exp_q.push_back(pack(8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h03;
        exp_q.push_back(pack(8'h0D, 8'h00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) n++;
            @(negedge clk);
        end
        chk("b2b_done_count", n, 2);
    endtask

    task automatic run_reset_abort();
        select = 4'b1000; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",      busy,      1'b0);
        chk("abort_done",      done,      1'b0);
        chk("abort_result",    result,    8'h00);
        chk("abort_result_hi", result_hi, 8'h00);
        chk("abort_z",         z,         1'b1);
        chk("abort_state",     state_dbg, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_done",      done,      1'b0);
        chk("rst_result",    result,    8'h00);
        chk("rst_result_hi", result_hi, 8'h00);
        chk("rst_z",         z,         1'b1);
        chk("rst_v",         v,         1'b0);
        chk("rst_dbz",       dbz,       1'b0);
        chk("rst_state",     state_dbg, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b0000, 8'h7F, 8'h01, 3'd0, pack(8'h80, 8'h00, 1'b0, 1'b1, 1'b0), 2, 1'b0, "add_ovf");
        run_b2b();
        run_op(4'b1000, 8'hFF, 8'hFF, 3'd0, pack(8'h01, 8'hFE, 1'b0, 1'b0, 1'b0), W + 2, 1'b1, "mul_ff");
        run_op(4'b1000, 8'h0D, 8'h0B, 3'd0, pack(8'h8F, 8'h00, 1'b0, 1'b0, 1'b0), W + 2, 1'b0, "mul_small");
        run_op(4'b0101, 8'h01, 8'h00, 3'd7, pack(8'h80, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "sll");
        run_op(4'b0110, 8'h80, 8'h00, 3'd7, pack(8'h01, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "srl");
        run_op(4'b0100, 8'h03, 8'h09, 3'd0, pack(8'h01, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "slt");
        run_op(4'b0011, 8'h0F, 8'hF0, 3'd0, pack(8'h00, 8'h00, 1'b1, 1'b0, 1'b0), 2, 1'b0, "nor");
        run_op(4'b0001, 8'hA5, 8'h3C, 3'd0, pack(8'h24, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "and");
        run_op(4'b0010, 8'hA0, 8'h05, 3'd0, pack(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "or");
        run_op(4'b0000, 8'h80, 8'h80, 3'd0, pack(8'h00, 8'h00, 1'b1, 1'b1, 1'b0), 2, 1'b0, "add_wrap");
        run_op(4'b0111, 8'h80, 8'h01, 3'd0, pack(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0), 2, 1'b0, "sub_ovf");
        run_op(4'b1111, 8'h10, 8'h20, 3'd0, pack(8'h30, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "unknown_op");
`ifdef ALU_MC_DIV_EN
        run_op(4'b1001, 8'd200, 8'd7, 3'd0, pack(8'd28, 8'h00, 1'b0, 1'b0, 1'b0), W + 2, 1'b0, "div");
        run_op(4'b1010, 8'd200, 8'd7, 3'd0, pack(8'd4,  8'h00, 1'b0, 1'b0, 1'b0), W + 2, 1'b0, "rem");
        run_op(4'b1001, 8'h33, 8'h00, 3'd0, pack(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1), W + 2, 1'b0, "div_zero");
        run_op(4'b1010, 8'h33, 8'h00, 3'd0, pack(8'h33, 8'h00, 1'b0, 1'b0, 1'b1), W + 2, 1'b0, "rem_zero");
        run_op(4'b0000, 8'h02, 8'h03, 3'd0, pack(8'h05, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "add_clr_dbz");
`else
        run_op(4'b1001, 8'h03, 8'h04, 3'd0, pack(8'h07, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "div_as_add");
        run_op(4'b1010, 8'h7F, 8'h01, 3'd0, pack(8'h80, 8'h00, 1'b0, 1'b1, 1'b0), 2, 1'b0, "rem_as_add");
`endif
        run_reset_abort();
        run_op(4'b0000, 8'h01, 8'h01, 3'd0, pack(8'h02, 8'h00, 1'b0, 1'b0, 1'b0), 2, 1'b0, "add_after_rst");

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
